// File: rtl/axis_pixel_packer.sv
// rtl/axis_pixel_packer.sv - packs IN_BYTES pixels into OUT_BYTES AXI4-Stream words
// Byte accumulator feeding a registered output stage that holds under backpressure.
module axis_pixel_packer #(
    parameter int IN_BYTES  = 3,
    parameter int OUT_BYTES = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [8*IN_BYTES-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic                   in_eol,
    output logic                   in_ready,
    output logic [8*OUT_BYTES-1:0] out_stream_tdata,
    output logic [OUT_BYTES-1:0]   out_stream_tkeep,
    output logic                   out_stream_tlast,
    output logic                   out_stream_tuser,
    output logic                   out_stream_tvalid,
    input  logic                   out_stream_tready,
    output logic                   err_sof_midline
);
    localparam int ACC = OUT_BYTES + IN_BYTES - 1;
    localparam int CW  = $clog2(ACC + 1);
    localparam logic [CW-1:0] OUT_CNT = CW'(OUT_BYTES);
    localparam logic [CW-1:0] IN_CNT  = CW'(IN_BYTES);

    logic [8*ACC-1:0]       r_buf;
    logic [CW-1:0]          r_cnt;
    logic                   r_flush_pend;
    logic                   r_sof_pend;
    logic                   r_err;
    logic [8*OUT_BYTES-1:0] r_tdata;
    logic [OUT_BYTES-1:0]   r_tkeep;
    logic                   r_tlast;
    logic                   r_tuser;
    logic                   r_tvalid;

    logic                   w_load;
    logic [CW-1:0]          w_take;
    logic [CW-1:0]          w_cnt_after;
    logic [8*ACC-1:0]       w_buf_after;
    logic [8*ACC-1:0]       w_pix_ext;
    logic [OUT_BYTES-1:0]   w_keep;
    logic                   w_tlast;
    logic                   w_accept;
    logic                   w_restart;

    // Bytes at and above r_cnt are always zero, so partial words need no masking.
    always_comb begin
        w_load      = (!r_tvalid || out_stream_tready)
                      && ((r_cnt >= OUT_CNT) || (r_flush_pend && (r_cnt != '0)));
        w_take      = (r_cnt >= OUT_CNT) ? OUT_CNT : r_cnt;
        w_cnt_after = w_load ? (r_cnt - w_take) : r_cnt;
        w_buf_after = w_load ? (r_buf >> (8 * OUT_BYTES)) : r_buf;
        w_tlast     = r_flush_pend && (r_cnt <= OUT_CNT);
        w_pix_ext   = {{(8*(ACC-IN_BYTES)){1'b0}}, in_data};
        w_keep      = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            w_keep[i] = (CW'(i) < r_cnt);
        end
        in_ready  = !areset && !r_flush_pend && ((r_cnt < OUT_CNT) || w_load);
        w_accept  = in_valid && in_ready;
        w_restart = w_accept && in_sof && (w_cnt_after != '0);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_sof_pend   <= 1'b0;
            r_err        <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_tvalid     <= 1'b0;
        end else begin
            if (w_load) begin
                r_tdata  <= r_buf[8*OUT_BYTES-1:0];
                r_tkeep  <= w_keep;
                r_tlast  <= w_tlast;
                r_tuser  <= r_sof_pend;
                r_tvalid <= 1'b1;
            end else if (out_stream_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_accept && in_sof) begin
                r_sof_pend <= 1'b1;
            end else if (w_load) begin
                r_sof_pend <= 1'b0;
            end

            if (w_accept && in_eol) begin
                r_flush_pend <= 1'b1;
            end else if (w_load && w_tlast) begin
                r_flush_pend <= 1'b0;
            end

            // A frame start with bytes still pending drops them and restarts packing.
            if (w_restart) begin
                r_buf <= w_pix_ext;
                r_cnt <= IN_CNT;
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_buf <= w_buf_after | (w_pix_ext << {w_cnt_after, 3'b000});
                r_cnt <= w_cnt_after + IN_CNT;
            end else begin
                r_buf <= w_buf_after;
                r_cnt <= w_cnt_after;
            end
        end
    end

    assign out_stream_tdata  = r_tdata;
    assign out_stream_tkeep  = r_tkeep;
    assign out_stream_tlast  = r_tlast;
    assign out_stream_tuser  = r_tuser;
    assign out_stream_tvalid = r_tvalid;
    assign err_sof_midline   = r_err;
endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb/tb_axis_pixel_packer.sv - scoreboard bench for axis_pixel_packer (IN=3, OUT=4)
module tb_axis_pixel_packer;
    localparam int INB  = 3;
    localparam int OUTB = 4;

    typedef struct packed {
        logic [8*OUTB-1:0] data;
        logic [OUTB-1:0]   keep;
        logic              last;
        logic              user;
    } word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8*INB-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic              in_eol = 1'b0;
    logic              in_ready;
    logic [8*OUTB-1:0] tdata;
    logic [OUTB-1:0]   tkeep;
    logic              tlast;
    logic              tuser;
    logic              tvalid;
    logic              tready = 1'b1;
    logic              err;

    int checks = 0;
    int errors = 0;
    int tready_mode = 0;

    logic [7:0] pend_q[$];
    word_t      exp_q[$];
    bit         m_sof = 1'b0;
    bit         m_err = 1'b0;

    axis_pixel_packer #(.IN_BYTES(INB), .OUT_BYTES(OUTB)) dut (
        .aclk(clk), .areset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_ready(in_ready),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
        .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .err_sof_midline(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a line is its byte stream cut into OUTB-byte words, the last one flagged.
    function automatic void emit(bit last);
        word_t w = '0;
        for (int i = 0; i < OUTB; i++) begin
            if (pend_q.size() > 0) begin
                w.data[i*8 +: 8] = pend_q.pop_front();
                w.keep[i] = 1'b1;
            end
        end
        w.last = last;
        w.user = m_sof;
        m_sof = 1'b0;
        exp_q.push_back(w);
    endfunction

    function automatic void model_accept(logic [8*INB-1:0] d, bit sof, bit eol);
        if (sof && pend_q.size() != 0) begin
            pend_q.delete();
            m_err = 1'b1;
        end
        for (int i = 0; i < INB; i++) pend_q.push_back(d[i*8 +: 8]);
        if (sof) m_sof = 1'b1;
        if (eol) begin
            while (pend_q.size() > 0) emit(pend_q.size() <= OUTB);
        end else begin
            while (pend_q.size() >= OUTB) emit(1'b0);
        end
    endfunction

    function automatic logic [8*INB-1:0] pix(int b);
        return {8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0: tready = 1'b1;
                1: tready = ($urandom_range(0, 3) != 0);
                default: tready = 1'b0;
            endcase
        end
    end

    word_t w_cur;
    word_t w_prev;
    word_t w_exp;
    bit    stall_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            w_cur = {tdata, tkeep, tlast, tuser};
            if (stall_prev) chk("hold", {tvalid, w_cur}, {1'b1, w_prev});
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", w_cur);
                end else begin
                    w_exp = exp_q.pop_front();
                    chk("word", w_cur, w_exp);
                end
            end
            stall_prev = tvalid && !tready;
            w_prev = w_cur;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that took the pixel.
    task automatic send(input logic [8*INB-1:0] d, input bit sof, input bit eol, output int waits);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_eol   = eol;
        waits    = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, sof, eol);
                done = 1'b1;
            end else if (waits > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", waits);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) waits++;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int w;
    int n;
    int len;
    bit fsof;
    logic [31:0] r;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tlast_tuser", {tlast, tuser}, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full-rate line of 4 pixels, no stall expected.
        for (int p = 0; p < 4; p++) begin
            send(pix(3 * p), 1'b0, p == 3, w);
            chk("t1_no_stall", w, 0);
        end
        idle(4);

        // Short line with partial last word; latency of the completing pixel.
        send(pix(0), 1'b0, 1'b0, w);
        idle(2);
        send(pix(3), 1'b0, 1'b0, w);
        idle(0);
        @(negedge clk);
        chk("lat_edge_n", tvalid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge_n1", tvalid, 1);
        @(posedge clk);
        #1;
        send(pix(6), 1'b0, 1'b1, w);
        idle(4);

        // Backpressure: in_ready drops, output word held.
        tready_mode = 2;
        fork
            begin
                for (int p = 0; p < 4; p++) send(pix(3 * p), 1'b0, p == 3, w);
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("t3_stall_ready", in_ready, 0);
                chk("t3_hold_data", tdata, 32'h03020100);
                tready_mode = 0;
            end
        join
        idle(6);

        // Frames and a mid-line frame start.
        send(pix(8'h20), 1'b1, 1'b0, w);
        send(pix(8'h23), 1'b0, 1'b1, w);
        idle(2);
        send(pix(8'h30), 1'b1, 1'b0, w);
        send(pix(8'h33), 1'b0, 1'b0, w);
        send(pix(8'h36), 1'b0, 1'b1, w);
        idle(4);
        chk("t4_err_clear", err, 0);
        send(pix(8'h40), 1'b1, 1'b0, w);
        send(pix(8'h43), 1'b0, 1'b0, w);
        send(pix(8'h50), 1'b1, 1'b0, w);
        send(pix(8'h53), 1'b0, 1'b1, w);
        idle(6);
        chk("t4_err_set", err, m_err);

        // Reset mid-line with a word held on the output.
        tready_mode = 2;
        send(pix(8'h60), 1'b0, 1'b0, w);
        send(pix(8'h63), 1'b0, 1'b0, w);
        idle(2);
        chk("t5_tvalid_before", tvalid, 1);
        rst = 1'b1;
        exp_q.delete();
        pend_q.delete();
        m_sof = 1'b0;
        m_err = 1'b0;
        #1;
        chk("t5_async_tvalid", tvalid, 0);
        chk("t5_async_ready", in_ready, 0);
        chk("t5_async_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tready_mode = 0;
        for (int p = 0; p < 4; p++) send(pix(8'h10 + 3 * p), 1'b0, p == 3, w);
        idle(4);

        // Randomized lines, gaps and backpressure.
        tready_mode = 1;
        repeat (150) begin
            len  = $urandom_range(1, 8);
            fsof = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) begin
                r = $urandom;
                send(r[8*INB-1:0], fsof && (k == 0), k == len - 1, w);
                if ($urandom_range(0, 4) == 0) idle(1);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        tready_mode = 0;
        idle(0);
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("drain_empty", exp_q.size(), 0);
        chk("err_final", err, m_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
